// File: rtl/dvp_tx_pkg.sv
// Shared types and constants for the DVP test-pattern transmitter:
// FSM state encoding, pattern_sel codes and the eight colour-bar values.
package dvp_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VSYNC  = 3'd1,
    ST_VBACK  = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_VFRONT = 3'd4
  } tx_state_e;

  localparam logic [1:0] PAT_BARS    = 2'd0;
  localparam logic [1:0] PAT_GREY    = 2'd1;
  localparam logic [1:0] PAT_CHECKER = 2'd2;
  localparam logic [1:0] PAT_SOLID   = 2'd3;

  localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
  localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
  localparam logic [15:0] BAR_CYAN    = 16'h07FF;
  localparam logic [15:0] BAR_GREEN   = 16'h07E0;
  localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
  localparam logic [15:0] BAR_RED     = 16'hF800;
  localparam logic [15:0] BAR_BLUE    = 16'h001F;
  localparam logic [15:0] BAR_BLACK   = 16'h0000;

  // Bar colour by bar index, left to right.
  function automatic logic [15:0] bar_colour(input logic [2:0] idx);
    logic [15:0] c;
    case (idx)
      3'd0:    c = BAR_WHITE;
      3'd1:    c = BAR_YELLOW;
      3'd2:    c = BAR_CYAN;
      3'd3:    c = BAR_GREEN;
      3'd4:    c = BAR_MAGENTA;
      3'd5:    c = BAR_RED;
      3'd6:    c = BAR_BLUE;
      default: c = BAR_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/dvp_pattern_gen.sv
// Per-pixel RGB565 generator. Output is registered once, so the parent
// presents the pixel position one clock before it is needed.
module dvp_pattern_gen
  import dvp_tx_pkg::*;
#(
  parameter int H_PIXEL = 480
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] x_i,
  input  logic [10:0] y_i,
  input  logic [1:0]  sel_i,
  input  logic [15:0] solid_i,
  output logic [15:0] rgb565_o
);

  localparam int          BAR_W   = H_PIXEL / 8;
  localparam logic [10:0] BAR_DIV = 11'((BAR_W > 0) ? BAR_W : 1);

  logic [10:0] bar_idx;
  logic [15:0] rgb_d, rgb_q;
  logic        unused_y;

  assign bar_idx  = x_i / BAR_DIV;
  // Only y[4] matters (checker); the rest of the line index is ignored.
  assign unused_y = ^{y_i[10:5], y_i[3:0]};

  // Pattern selection; columns beyond the last full bar stay black.
  always_comb begin
    rgb_d = 16'h0000;
    case (sel_i)
      PAT_BARS:    if ((BAR_W > 0) && (bar_idx < 11'd8)) rgb_d = bar_colour(bar_idx[2:0]);
      PAT_GREY:    rgb_d = {x_i[8:4], x_i[8:3], x_i[8:4]};
      PAT_CHECKER: rgb_d = (x_i[4] ^ y_i[4]) ? 16'hFFFF : 16'h0000;
      default:     rgb_d = solid_i;
    endcase
  end

  // Single pipeline register on the generated pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rgb_q <= 16'h0000;
    else        rgb_q <= rgb_d;
  end

  assign rgb565_o = rgb_q;

endmodule

// File: rtl/dvp_pattern_tx.sv
// DVP camera-interface test-pattern transmitter (RGB565, two bytes/pixel).
// Optional frame counter output enabled by defining DVP_TX_FRAME_CNT_EN.
//
//   state     | meaning
//   ----------+------------------------------------------------------
//   ST_IDLE   | waiting for enable; pattern/solid latched on exit
//   ST_VSYNC  | VS_LINES line times, cam_vsync high
//   ST_VBACK  | VB_LINES line times of vertical back porch
//   ST_ACTIVE | V_PIXEL lines: 2*H_PIXEL href clocks + H_BLANK idle
//   ST_VFRONT | VF_LINES line times; frame_done on the last clock
module dvp_pattern_tx
  import dvp_tx_pkg::*;
#(
  parameter int H_PIXEL  = 480,
  parameter int V_PIXEL  = 272,
  parameter int H_BLANK  = 64,
  parameter int VS_LINES = 2,
  parameter int VB_LINES = 4,
  parameter int VF_LINES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  input  logic [15:0] solid_rgb,
  output logic        cam_vsync,
  output logic        cam_href,
  output logic [7:0]  cam_data,
  output logic        frame_done
`ifdef DVP_TX_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  localparam int          LINE_T    = 2 * H_PIXEL + H_BLANK;
  localparam logic [11:0] COL_LAST  = 12'(LINE_T - 1);
  localparam logic [11:0] HREF_COLS = 12'(2 * H_PIXEL);
  localparam logic [12:0] LINE_T13  = 13'(LINE_T);
  localparam logic [10:0] VS_LAST   = 11'(VS_LINES - 1);
  localparam logic [10:0] VB_LAST   = 11'(VB_LINES - 1);
  localparam logic [10:0] ACT_LAST  = 11'(V_PIXEL - 1);
  localparam logic [10:0] VF_LAST   = 11'(VF_LINES - 1);

  tx_state_e   state_q, state_d;
  logic [11:0] col_q, col_d;
  logic [10:0] line_q, line_d;
  logic [1:0]  sel_q;
  logic [15:0] solid_q;
  logic        vsync_q, href_q, done_q;
  logic [7:0]  data_q;

  logic        href_d, done_d;
  logic [7:0]  data_d;
  logic [10:0] lines_last;
  logic        line_end, state_end;

  logic [12:0] col_p2;
  logic        wrap_p2;
  logic [11:0] col_ahead;
  logic [10:0] y_ahead;
  logic [15:0] gen_rgb;
  logic        unused_col_lsb;

  // Number of line times the current state lasts (minus one).
  always_comb begin
    lines_last = VS_LAST;
    case (state_q)
      ST_VBACK:  lines_last = VB_LAST;
      ST_ACTIVE: lines_last = ACT_LAST;
      ST_VFRONT: lines_last = VF_LAST;
      default:   lines_last = VS_LAST;
    endcase
  end

  assign line_end  = (col_q == COL_LAST);
  assign state_end = line_end && (line_q == lines_last);

  // Next state and position; column and line counters wrap per line/state.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    line_d  = line_q;
    if (state_q == ST_IDLE) begin
      col_d  = '0;
      line_d = '0;
      if (enable) state_d = ST_VSYNC;
    end else if (line_end) begin
      col_d = '0;
      if (state_end) begin
        line_d = '0;
        case (state_q)
          ST_VSYNC:  state_d = ST_VBACK;
          ST_VBACK:  state_d = ST_ACTIVE;
          ST_ACTIVE: state_d = ST_VFRONT;
          default:   state_d = ST_IDLE;
        endcase
      end else begin
        line_d = line_q + 11'd1;
      end
    end else begin
      col_d = col_q + 12'd1;
    end
  end

  // The generator register plus the output register add two clocks, so the
  // generator is fed the position two clocks ahead of the current one.
  assign col_p2         = {1'b0, col_q} + 13'd2;
  assign wrap_p2        = (col_p2 >= LINE_T13);
  assign col_ahead      = wrap_p2 ? 12'(col_p2 - LINE_T13) : col_p2[11:0];
  assign unused_col_lsb = col_ahead[0];

  // Look-ahead line index; outside ACTIVE it points at the first active line.
  always_comb begin
    y_ahead = '0;
    if (state_q == ST_ACTIVE) y_ahead = wrap_p2 ? (line_q + 11'd1) : line_q;
  end

  dvp_pattern_gen #(
    .H_PIXEL (H_PIXEL)
  ) u_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .x_i      (col_ahead[11:1]),
    .y_i      (y_ahead),
    .sel_i    (sel_q),
    .solid_i  (solid_q),
    .rgb565_o (gen_rgb)
  );

  assign href_d = (state_d == ST_ACTIVE) && (col_d < HREF_COLS);
  assign done_d = (state_d == ST_VFRONT) && (col_d == COL_LAST) && (line_d == VF_LAST);
  assign data_d = !href_d ? 8'h00 : (col_d[0] ? gen_rgb[7:0] : gen_rgb[15:8]);

  // Frame FSM, pattern latch and registered DVP outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      col_q   <= '0;
      line_q  <= '0;
      sel_q   <= '0;
      solid_q <= '0;
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      data_q  <= 8'h00;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      line_q  <= line_d;
      if ((state_q == ST_IDLE) && enable) begin
        sel_q   <= pattern_sel;
        solid_q <= solid_rgb;
      end
      vsync_q <= (state_d == ST_VSYNC);
      href_q  <= href_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  assign cam_vsync  = vsync_q;
  assign cam_href   = href_q;
  assign cam_data   = data_q;
  assign frame_done = done_q;

`ifdef DVP_TX_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  // Completed-frame counter, advances on the same edge as frame_done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      frame_cnt_q <= 16'h0000;
    else if (done_d) frame_cnt_q <= frame_cnt_q + 16'd1;
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_dvp_pattern_tx.sv
// Self-checking bench for dvp_pattern_tx with a small frame geometry.
module tb_dvp_pattern_tx;

  localparam int H       = 16;
  localparam int V       = 4;
  localparam int HB      = 4;
  localparam int VS      = 1;
  localparam int VB      = 1;
  localparam int VF      = 1;
  localparam int LINE_T  = 2 * H + HB;
  localparam int FRAME_T = (VS + VB + V + VF) * LINE_T;
  localparam int ACT0    = (VS + VB) * LINE_T;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [1:0]  pattern_sel;
  logic [15:0] solid_rgb;
  logic        cam_vsync, cam_href, frame_done;
  logic [7:0]  cam_data;
`ifdef DVP_TX_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  always #5 clk = ~clk;

  dvp_pattern_tx #(
    .H_PIXEL (H), .V_PIXEL (V), .H_BLANK (HB),
    .VS_LINES(VS), .VB_LINES(VB), .VF_LINES(VF)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .pattern_sel (pattern_sel),
    .solid_rgb   (solid_rgb),
    .cam_vsync   (cam_vsync),
    .cam_href    (cam_href),
    .cam_data    (cam_data),
    .frame_done  (frame_done)
`ifdef DVP_TX_FRAME_CNT_EN
    ,
    .frame_cnt   (frame_cnt)
`endif
  );

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;
  int exp_cnt = 0;

  logic [15:0] bar_tab [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                               16'hF81F, 16'hF800, 16'h001F, 16'h0000};
  logic [7:0]  l0_exp  [10] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                                8'hE0, 8'hFF, 8'hE0, 8'h07, 8'hFF};

  int         m_vs_cnt, m_href_pulses, m_href_min, m_href_max, m_done_k;
  logic [7:0] m_line0 [$];
  logic [7:0] m_act   [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] outs();
    return {cam_vsync, cam_href, frame_done, cam_data};
  endfunction

  // Reference pixel colour from column x and active line y.
  function automatic logic [15:0] ref_pixel(input int x, input int y,
                                            input logic [1:0] sel, input logic [15:0] solid);
    int w, r, g;
    case (sel)
      2'd0: begin
        w = H / 8;
        if (w > 0 && (x / w) < 8) return bar_tab[x / w];
        return 16'h0000;
      end
      2'd1: begin
        r = (x >> 4) & 31;
        g = (x >> 3) & 63;
        return 16'((r << 11) | (g << 5) | r);
      end
      2'd2: return (((x / 16) + (y / 16)) % 2 == 1) ? 16'hFFFF : 16'h0000;
      default: return solid;
    endcase
  endfunction

  // Expected {vsync, href, frame_done, data} for clock k after vsync rises.
  function automatic logic [10:0] exp_out(input int k, input logic [1:0] sel,
                                          input logic [15:0] solid);
    int ln, c, y;
    logic vs, hr, dn;
    logic [15:0] pix;
    logic [7:0] d;
    ln  = k / LINE_T;
    c   = k % LINE_T;
    y   = ln - (VS + VB);
    vs  = (ln < VS);
    hr  = (y >= 0) && (y < V) && (c < 2 * H);
    dn  = (k == FRAME_T - 1);
    pix = ref_pixel(c / 2, y, sel, solid);
    d   = !hr ? 8'h00 : ((c % 2 == 0) ? pix[15:8] : pix[7:0]);
    return {vs, hr, dn, d};
  endfunction

  // Start a frame (caller is just past a negedge) and check every clock.
  task automatic run_frame(input logic [1:0] sel, input logic [15:0] solid, input bit keep_en,
                           input int chg_k, input logic [1:0] chg_sel,
                           input int drop_k, input int rst_k);
    int cur_len;
    cur_len = 0;
    pattern_sel = sel;
    solid_rgb   = solid;
    enable      = 1'b1;
    m_vs_cnt = 0; m_href_pulses = 0; m_href_min = 99999; m_href_max = 0; m_done_k = -1;
    m_line0.delete();
    m_act.delete();
    for (int k = 0; k < FRAME_T; k++) begin
      @(negedge clk);
      check($sformatf("frame sel=%0d k=%0d", sel, k), outs(), exp_out(k, sel, solid));
      if (cam_vsync) m_vs_cnt++;
      if (frame_done) m_done_k = k;
      if (cam_href) begin
        cur_len++;
        m_act.push_back(cam_data);
        if (k >= ACT0 && k < ACT0 + LINE_T && m_line0.size() < 10) m_line0.push_back(cam_data);
      end else if (cur_len > 0) begin
        m_href_pulses++;
        if (cur_len < m_href_min) m_href_min = cur_len;
        if (cur_len > m_href_max) m_href_max = cur_len;
        cur_len = 0;
      end
      if (k == chg_k) pattern_sel = chg_sel;
      if (k == drop_k) enable = 1'b0;
      if (k == rst_k) begin
        #2 rst_n = 1'b0;
        #1 check("async reset outputs", outs(), 11'h000);
        enable = 1'b0;
        repeat (3) @(negedge clk);
        check("outputs held in reset", outs(), 11'h000);
        rst_n   = 1'b1;
        exp_cnt = 0;
`ifdef DVP_TX_FRAME_CNT_EN
        check("frame_cnt after reset", frame_cnt, 16'h0000);
`endif
        return;
      end
    end
    @(negedge clk);
    check("idle clock after frame", outs(), 11'h000);
    if (!keep_en) enable = 1'b0;
    exp_cnt++;
`ifdef DVP_TX_FRAME_CNT_EN
    check("frame_cnt", frame_cnt, 16'(exp_cnt));
`endif
  endtask

  initial begin
    logic [10:0] idle_or;
    int bad, nz;
    logic [1:0]  rsel;
    logic [15:0] rsolid;

    rst_n = 1'b0; enable = 1'b0; pattern_sel = 2'd0; solid_rgb = 16'h0000;
    repeat (3) @(negedge clk);
    check("outputs in reset", outs(), 11'h000);
    rst_n = 1'b1;
`ifdef DVP_TX_FRAME_CNT_EN
    check("frame_cnt reset", frame_cnt, 16'h0000);
`endif

    // Idle with enable low: nothing moves.
    idle_or = '0;
    repeat (100) begin @(negedge clk); idle_or |= outs(); end
    check("idle enable=0 outputs", idle_or, 11'h000);

    // Colour bars, frame timing against the literal figures.
    run_frame(2'd0, 16'h1234, 1'b0, -1, 2'd0, -1, -1);
    check("vsync high clocks", m_vs_cnt, 36);
    check("href pulses", m_href_pulses, 4);
    check("href min length", m_href_min, 32);
    check("href max length", m_href_max, 32);
    check("vsync fall to frame end", m_done_k + 1 - m_vs_cnt, 216);
    check("line0 byte count", m_line0.size(), 10);
    for (int i = 0; i < 10; i++)
      check($sformatf("line0 byte %0d", i), (i < m_line0.size()) ? m_line0[i] : 8'hxx, l0_exp[i]);

    // Solid colour.
    run_frame(2'd3, 16'hA5C3, 1'b0, -1, 2'd0, -1, -1);
    bad = 0;
    foreach (m_act[i]) if (m_act[i] !== ((i % 2 == 0) ? 8'hA5 : 8'hC3)) bad++;
    check("solid active bytes", m_act.size(), 128);
    check("solid byte pairs wrong", bad, 0);

    // pattern_sel changed mid-ACTIVE: this frame stays bars, the next is checker.
    run_frame(2'd0, 16'h0000, 1'b1, ACT0 + 40, 2'd2, -1, -1);
    nz = 0;
    foreach (m_act[i]) if (m_act[i] != 8'h00) nz++;
    check("bars frame has colour", nz > 0, 1);
    run_frame(2'd2, 16'h0000, 1'b0, -1, 2'd0, -1, -1);
    nz = 0;
    foreach (m_act[i]) if (m_act[i] != 8'h00) nz++;
    check("checker frame all black", nz, 0);

    // enable dropped during VBACK: frame completes and the FSM stays idle.
    run_frame(2'd1, 16'h0000, 1'b0, -1, 2'd0, VS * LINE_T + 10, -1);
    check("frame_done after enable drop", m_done_k, FRAME_T - 1);
    idle_or = '0;
    repeat (60) begin @(negedge clk); idle_or |= outs(); end
    check("idle after dropped enable", idle_or, 11'h000);

    // Random pattern/solid frames.
    for (int n = 0; n < 3; n++) begin
      rsel   = 2'($urandom_range(0, 3));
      rsolid = 16'($urandom);
      run_frame(rsel, rsolid, 1'b0, -1, 2'd0, -1, -1);
    end

    // Reset mid-ACTIVE, then a clean frame starting with vsync.
    run_frame(2'd0, 16'h0000, 1'b0, -1, 2'd0, -1, ACT0 + 50);
    run_frame(2'd1, 16'h0000, 1'b0, -1, 2'd0, -1, -1);
    check("vsync clocks after reset", m_vs_cnt, 36);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
